// File: rtl/dmi_arb_pkg.sv
// Shared debug-transport types: DMI request/response structs, DTM status codes
// and the state encoding of the DMI arbiter.
package dmi_arb_pkg;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_FAILED  = 2'h2;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DELIVER
  } dmi_arb_state_e;

endpackage

// File: rtl/dmi_arb_rr_pick.sv
// Combinational round-robin selector: first set request at or after the
// pointer, wrapping, returned both one-hot and as an index.
module dmi_arb_rr_pick #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NumReq) s = s - NumReq;
    return IdxW'(s);
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // one unassigned, which would otherwise infer a latch.
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!any_o && req_i[wrap_idx(ptr_i, i)]) begin
        any_o                    = 1'b1;
        idx_o                    = wrap_idx(ptr_i, i);
        gnt_o[wrap_idx(ptr_i, i)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmi_arb.sv
// Round-robin arbiter sharing one DMI port between several debug transports,
// one outstanding access at a time, with a lost-response timeout.
module dmi_arb
  import dmi_arb_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic      [NumReq-1:0] req_valid_i,
  output logic      [NumReq-1:0] req_ready_o,
  input  dmi_req_t  [NumReq-1:0] req_i,
  output logic      [NumReq-1:0] resp_valid_o,
  input  logic      [NumReq-1:0] resp_ready_i,
  output dmi_resp_t              resp_o,
  output logic                   dmi_req_valid_o,
  input  logic                   dmi_req_ready_i,
  output dmi_req_t               dmi_req_o,
  input  logic                   dmi_resp_valid_i,
  output logic                   dmi_resp_ready_o,
  input  dmi_resp_t              dmi_resp_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] TimeoutLast =
    CntW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  dmi_arb_state_e  state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] idx_q, idx_d;
  dmi_req_t        req_q, req_d;
  dmi_resp_t       resp_q, resp_d;
  logic            drop_q, drop_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [NumReq-1:0] pick_gnt;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_any;

  dmi_arb_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    req_d       = req_q;
    resp_d      = resp_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    req_ready_o = '0;

    unique case (state_q)
      ST_IDLE: begin
        // A response still owed to a timed-out access must drain first.
        if (!drop_q && pick_any) begin
          req_ready_o = pick_gnt;
          req_d       = req_i[pick_idx];
          idx_d       = pick_idx;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dmi_req_ready_i) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q + CntW'(1);
        if (dmi_resp_valid_i) begin
          resp_d  = dmi_resp_i;
          state_d = ST_DELIVER;
        end else if (TimeoutCycles != 0 && cnt_q == TimeoutLast) begin
          resp_d  = '{data: '0, resp: DTM_FAILED};
          drop_d  = 1'b1;
          state_d = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (resp_ready_i[idx_q]) begin
          ptr_d   = (idx_q == IdxW'(NumReq - 1)) ? '0 : idx_q + IdxW'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (drop_q && dmi_resp_valid_i) drop_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value, independent of statement order.
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      req_q   <= '0;
      resp_q  <= '0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    resp_valid_o = '0;
    if (state_q == ST_DELIVER) resp_valid_o[idx_q] = 1'b1;
  end

  assign dmi_req_valid_o  = (state_q == ST_REQ);
  assign dmi_req_o        = req_q;
  assign dmi_resp_ready_o = (state_q == ST_RESP) || drop_q;
  assign resp_o           = resp_q;

endmodule

// File: tb/tb_dmi_arb.sv
// Self-checking bench for dmi_arb: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_dmi_arb;
  import dmi_arb_pkg::*;

  localparam int NR = 2;
  localparam int IW = $clog2(NR);
  localparam int TO = 8;

  logic                  clk;
  logic                  rst_i;
  logic      [NR-1:0]    req_valid_i;
  logic      [NR-1:0]    req_ready_o;
  dmi_req_t  [NR-1:0]    req_i;
  logic      [NR-1:0]    resp_valid_o;
  logic      [NR-1:0]    resp_ready_i;
  dmi_resp_t             resp_o;
  logic                  dmi_req_valid_o;
  logic                  dmi_req_ready_i;
  dmi_req_t              dmi_req_o;
  logic                  dmi_resp_valid_i;
  logic                  dmi_resp_ready_o;
  dmi_resp_t             dmi_resp_i;

  int checks = 0;
  int errors = 0;
  int grant_log[$];

  dmi_arb #(.NumReq(NR), .TimeoutCycles(TO)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_i            (req_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .resp_o           (resp_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_req_o        (dmi_req_o),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .dmi_resp_i       (dmi_resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs are driven 1 time unit after the edge; outputs are read 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic dmi_req_t rand_req();
    return '{addr: 7'($urandom), op: ($urandom_range(0, 1) != 0) ? DTM_READ : DTM_WRITE,
             data: $urandom};
  endfunction

  // Downstream model: a deterministic function of the request it was given.
  function automatic dmi_resp_t resp_of(input dmi_req_t r);
    return '{data: r.data ^ 32'h5A5A_0000 ^ {25'd0, r.addr}, resp: r.addr[1:0]};
  endfunction

  function automatic int model_pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[IW'((p + k) % NR)]) return (p + k) % NR;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_i            = 1'b1;
    req_valid_i      = '0;
    req_i            = '0;
    resp_ready_i     = '0;
    dmi_req_ready_i  = 1'b0;
    dmi_resp_valid_i = 1'b0;
    dmi_resp_i       = '0;
    repeat (2) tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++; if (req_ready_o !== '0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready_o); end
    checks++; if (resp_valid_o !== '0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid_o); end
    checks++; if (dmi_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_dmi_req_valid got %b exp 0", dmi_req_valid_o); end
    checks++; if (dmi_resp_ready_o !== 1'b0) begin errors++; $display("FAIL reset_dmi_resp_ready got %b exp 0", dmi_resp_ready_o); end
    checks++; if (resp_o !== '0) begin errors++; $display("FAIL reset_resp got %h exp 0", resp_o); end
    checks++; if (dmi_req_o !== '0) begin errors++; $display("FAIL reset_dmi_req got %h exp 0", dmi_req_o); end
  endtask

  task automatic test_single();
    dmi_req_t  rq;
    dmi_resp_t rs;
    logic      seen1;
    rq = '{addr: 7'h11, op: DTM_READ, data: 32'h0};
    rs = '{data: 32'h0040_0382, resp: 2'h0};
    do_reset();
    req_i[0] = rq; req_valid_i = 2'b01;
    dmi_req_ready_i = 1'b1; dmi_resp_valid_i = 1'b1; dmi_resp_i = rs; resp_ready_i = 2'b01;
    settle();
    seen1 = req_ready_o[1];
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL single_accept got %b exp 01", req_ready_o); end
    tick(); req_valid_i = '0; settle();
    seen1 |= req_ready_o[1];
    checks++; if (dmi_req_valid_o !== 1'b1 || dmi_req_o !== rq) begin errors++; $display("FAIL single_dmi_req got %b/%h exp 1/%h", dmi_req_valid_o, dmi_req_o, rq); end
    tick(); settle();
    seen1 |= req_ready_o[1];
    checks++; if (dmi_resp_ready_o !== 1'b1 || resp_valid_o !== 2'b00) begin errors++; $display("FAIL single_resp_phase got %b/%b exp 1/00", dmi_resp_ready_o, resp_valid_o); end
    tick(); settle();
    seen1 |= req_ready_o[1];
    checks++; if (resp_valid_o !== 2'b01 || resp_o !== rs) begin errors++; $display("FAIL single_deliver got %b/%h exp 01/%h", resp_valid_o, resp_o, rs); end
    tick(); dmi_resp_valid_i = 1'b0; settle();
    seen1 |= req_ready_o[1];
    checks++; if (resp_valid_o !== 2'b00) begin errors++; $display("FAIL single_done got %b exp 00", resp_valid_o); end
    checks++; if (seen1 !== 1'b0) begin errors++; $display("FAIL single_no_grant1 got %b exp 0", seen1); end
  endtask

  // Transaction-level traffic: requesters raise requests at random, a model
  // downstream answers after a random delay, and every grant, forwarded
  // request and delivered response is compared with the round-robin rules.
  task automatic run_traffic(input int n_txn, input bit all_valid, input int max_dly);
    logic [NR-1:0] pend;
    logic [NR-1:0] exp_oh;
    dmi_req_t      preq[NR];
    dmi_req_t      exp_req;
    dmi_resp_t     ds_resp;
    bit            busy, ds_have, resp_ret;
    int            owner, ptr, done, ds_wait, g, cyc;
    pend = '0; busy = 0; ds_have = 0; resp_ret = 0;
    owner = 0; ptr = 0; done = 0; ds_wait = 0; cyc = 0;
    exp_req = '0; ds_resp = '0;
    for (int r = 0; r < NR; r++) preq[r] = '0;
    grant_log.delete();
    while (done < n_txn && cyc < 4000) begin
      tick(); cyc++;
      for (int r = 0; r < NR; r++) begin
        if (!pend[IW'(r)] && (all_valid || $urandom_range(0, 2) == 0)) begin
          pend[IW'(r)] = 1'b1;
          preq[r]      = rand_req();
        end
        req_i[IW'(r)] = preq[r];
      end
      req_valid_i      = pend;
      dmi_req_ready_i  = ($urandom_range(0, max_dly) < 2);
      dmi_resp_valid_i = ds_have && (ds_wait == 0);
      dmi_resp_i       = ds_resp;
      if (ds_have && ds_wait > 0) ds_wait--;
      resp_ready_i     = all_valid ? '1 : NR'($urandom);
      settle();

      g = model_pick(pend, ptr);
      exp_oh = '0;
      if (!busy && g >= 0) exp_oh[IW'(g)] = 1'b1;
      checks++;
      if (req_ready_o !== exp_oh) begin errors++; $display("FAIL traffic_grant got %b exp %b", req_ready_o, exp_oh); end
      if (!busy && g >= 0) begin
        busy = 1; owner = g; exp_req = preq[g]; pend[IW'(g)] = 1'b0;
        grant_log.push_back(g);
      end

      if (resp_valid_o !== '0) begin
        exp_oh = '0; exp_oh[IW'(owner)] = 1'b1;
        checks++;
        if (!resp_ret || resp_valid_o !== exp_oh || resp_o !== resp_of(exp_req)) begin
          errors++;
          $display("FAIL traffic_deliver got %b/%h exp %b/%h (returned %0d)", resp_valid_o, resp_o, exp_oh, resp_of(exp_req), resp_ret);
        end
        if (resp_ready_i[IW'(owner)]) begin
          busy = 0; resp_ret = 0; ptr = (owner + 1) % NR; done++;
        end
      end

      if (dmi_req_valid_o && dmi_req_ready_i) begin
        checks++;
        if (!busy || dmi_req_o !== exp_req) begin errors++; $display("FAIL traffic_dmi_req got %h exp %h", dmi_req_o, exp_req); end
        ds_have = 1; ds_resp = resp_of(exp_req); ds_wait = $urandom_range(0, max_dly);
      end
      if (dmi_resp_valid_i && dmi_resp_ready_o) begin
        ds_have = 0; resp_ret = 1;
      end
    end
    checks++;
    if (done != n_txn) begin errors++; $display("FAIL traffic_budget completed %0d exp %0d", done, n_txn); end
  endtask

  task automatic test_round_robin();
    int exp_g[4] = '{0, 1, 0, 1};
    do_reset();
    run_traffic(4, 1'b1, 0);
    checks++;
    if (grant_log.size() != 4) begin
      errors++; $display("FAIL rr_count got %0d exp 4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grant_log[i] != exp_g[i]) begin errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, grant_log[i], exp_g[i]); end
      end
    end
  endtask

  task automatic test_req_stall();
    dmi_req_t  rq;
    dmi_resp_t rs;
    rq = rand_req();
    rs = resp_of(rq);
    do_reset();
    req_i[1] = rq; req_valid_i = 2'b10;
    settle();
    checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL stall_accept got %b exp 10", req_ready_o); end
    for (int i = 0; i < 50; i++) begin
      tick();
      req_valid_i = '0;
      req_i[1]    = rand_req();
      settle();
      checks++;
      if (dmi_req_valid_o !== 1'b1 || dmi_req_o !== rq || resp_valid_o !== '0) begin
        errors++; $display("FAIL stall_hold[%0d] got %b/%h/%b exp 1/%h/00", i, dmi_req_valid_o, dmi_req_o, resp_valid_o, rq);
      end
    end
    dmi_req_ready_i = 1'b1; dmi_resp_valid_i = 1'b1; dmi_resp_i = rs; resp_ready_i = 2'b10;
    tick(); tick(); settle();
    checks++; if (resp_valid_o !== 2'b10 || resp_o !== rs) begin errors++; $display("FAIL stall_deliver got %b/%h exp 10/%h", resp_valid_o, resp_o, rs); end
    tick(); dmi_resp_valid_i = 1'b0; settle();
    checks++; if (resp_valid_o !== 2'b00) begin errors++; $display("FAIL stall_done got %b exp 00", resp_valid_o); end
  endtask

  task automatic test_timeout();
    dmi_req_t  ra, rb;
    dmi_resp_t fail_rs, good;
    ra = rand_req(); rb = rand_req();
    fail_rs = '{data: 32'h0, resp: 2'h2};
    good    = resp_of(rb);
    do_reset();
    req_i[0] = ra; req_valid_i = 2'b01; dmi_req_ready_i = 1'b1;
    settle();
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL to_accept got %b exp 01", req_ready_o); end
    tick(); req_i[1] = rb; req_valid_i = 2'b10; settle();
    checks++; if (dmi_req_valid_o !== 1'b1) begin errors++; $display("FAIL to_req got %b exp 1", dmi_req_valid_o); end
    for (int k = 1; k <= TO; k++) begin
      tick(); settle();
      checks++;
      if (resp_valid_o !== '0 || dmi_resp_ready_o !== 1'b1 || req_ready_o !== '0) begin
        errors++; $display("FAIL to_wait[%0d] got %b/%b/%b exp 00/1/00", k, resp_valid_o, dmi_resp_ready_o, req_ready_o);
      end
    end
    tick(); settle();
    checks++; if (resp_valid_o !== 2'b01 || resp_o !== fail_rs) begin errors++; $display("FAIL to_fail_resp got %b/%h exp 01/%h", resp_valid_o, resp_o, fail_rs); end
    resp_ready_i = 2'b01;
    for (int k = 0; k < 20; k++) begin
      tick(); settle();
      checks++;
      if (req_ready_o !== '0 || dmi_resp_ready_o !== 1'b1 || resp_valid_o !== '0) begin
        errors++; $display("FAIL to_drop[%0d] got %b/%b/%b exp 00/1/00", k, req_ready_o, dmi_resp_ready_o, resp_valid_o);
      end
    end
    dmi_resp_valid_i = 1'b1; dmi_resp_i = resp_of(ra);
    settle();
    checks++; if (req_ready_o !== '0) begin errors++; $display("FAIL to_late_cycle got %b exp 00", req_ready_o); end
    tick(); dmi_resp_valid_i = 1'b0; resp_ready_i = 2'b10; settle();
    checks++; if (req_ready_o !== 2'b10 || resp_valid_o !== '0) begin errors++; $display("FAIL to_regrant got %b/%b exp 10/00", req_ready_o, resp_valid_o); end
    tick(); req_valid_i = '0; settle();
    checks++; if (dmi_req_valid_o !== 1'b1 || dmi_req_o !== rb) begin errors++; $display("FAIL to_req1 got %b/%h exp 1/%h", dmi_req_valid_o, dmi_req_o, rb); end
    dmi_resp_valid_i = 1'b1; dmi_resp_i = good;
    tick(); tick(); settle();
    checks++; if (resp_valid_o !== 2'b10 || resp_o !== good) begin errors++; $display("FAIL to_deliver1 got %b/%h exp 10/%h", resp_valid_o, resp_o, good); end
    tick(); dmi_resp_valid_i = 1'b0;
  endtask

  task automatic test_backpressure();
    dmi_req_t  ra;
    dmi_resp_t d;
    ra = rand_req(); d = resp_of(ra);
    do_reset();
    req_i[0] = ra; req_valid_i = 2'b01;
    dmi_req_ready_i = 1'b1; dmi_resp_valid_i = 1'b1; dmi_resp_i = d;
    settle();
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL bp_accept got %b exp 01", req_ready_o); end
    tick(); req_i[0] = rand_req(); req_i[1] = rand_req(); req_valid_i = 2'b11;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      dmi_resp_i = resp_of(rand_req());
      settle();
      checks++;
      if (resp_valid_o !== 2'b01 || resp_o !== d || req_ready_o !== '0) begin
        errors++; $display("FAIL bp_hold[%0d] got %b/%h/%b exp 01/%h/00", i, resp_valid_o, resp_o, req_ready_o, d);
      end
    end
    resp_ready_i = 2'b01;
    tick(); settle();
    checks++; if (req_ready_o !== 2'b10 || resp_valid_o !== '0) begin errors++; $display("FAIL bp_next_grant got %b/%b exp 10/00", req_ready_o, resp_valid_o); end
  endtask

  task automatic test_reset_mid();
    dmi_req_t  ra, rb;
    ra = rand_req(); rb = rand_req();
    do_reset();
    req_i[0] = ra; req_valid_i = 2'b01;
    dmi_req_ready_i = 1'b1; dmi_resp_valid_i = 1'b1; dmi_resp_i = resp_of(ra); resp_ready_i = 2'b11;
    settle();
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL rm_first got %b exp 01", req_ready_o); end
    tick(); req_valid_i = '0;
    repeat (3) tick();
    dmi_resp_valid_i = 1'b0; req_i[1] = rb; req_valid_i = 2'b10;
    settle();
    checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL rm_second got %b exp 10", req_ready_o); end
    tick(); req_valid_i = '0;
    tick(); settle();
    checks++; if (dmi_resp_ready_o !== 1'b1) begin errors++; $display("FAIL rm_in_resp got %b exp 1", dmi_resp_ready_o); end
    rst_i = 1'b1;
    tick(); rst_i = 1'b0; settle();
    checks++;
    if (req_ready_o !== '0 || resp_valid_o !== '0 || dmi_req_valid_o !== 1'b0 ||
        dmi_resp_ready_o !== 1'b0 || resp_o !== '0 || dmi_req_o !== '0) begin
      errors++; $display("FAIL rm_outputs got %b/%b/%b/%b/%h/%h exp all 0", req_ready_o, resp_valid_o, dmi_req_valid_o, dmi_resp_ready_o, resp_o, dmi_req_o);
    end
    req_valid_i = 2'b11;
    settle();
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL rm_regrant got %b exp 01", req_ready_o); end
    tick(); req_valid_i = '0;
  endtask

  task automatic test_random();
    do_reset();
    run_traffic(40, 1'b0, 4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_req_stall();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
